// File: rtl/l1_to_l2_instr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQS L1 instruction-cache misses onto one L2 port and
// routing L2 responses back by tag index. Optional stall counter: L2_INSTR_ARB_PERF_EN.
module l1_to_l2_instr_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_IN_WIDTH = 8,
  localparam int IDX_W         = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQS-1:0]              req_valid_i,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_i,
  output logic [NUM_REQS-1:0]              req_ready_o,
  output logic                             mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr_o,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag_o,
  input  logic                             mem_req_ready_i,
  input  logic                             mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data_i,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag_i,
  output logic                             mem_rsp_ready_o,
  output logic [NUM_REQS-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_data_o,
  output logic [TAG_IN_WIDTH-1:0]          rsp_tag_o,
  input  logic [NUM_REQS-1:0]              rsp_ready_i
`ifdef L2_INSTR_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cnt_o
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a valid source holds its payload stable until that edge, ready may depend on valid.

  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        next_ptr;
  logic [NUM_REQS-1:0]     grant_oh;
  logic                    found;
  logic                    stage_ready;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [TAG_IN_WIDTH-1:0] sel_tag;

  // Two passes: first the indices at or above rr_ptr, then wrap to the lowest index.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!found && req_valid_i[k] && (IDX_W'(k) >= rr_ptr)) begin
        found     = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!found && req_valid_i[k]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_addr = '0;
    sel_tag  = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (found && (grant_idx == IDX_W'(k))) begin
        grant_oh[k] = 1'b1;
        sel_addr    = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_tag     = req_tag_i[k*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      end
    end
  end

  assign next_ptr    = (grant_idx == IDX_W'(NUM_REQS-1)) ? '0 : grant_idx + IDX_W'(1);
  assign stage_ready = !mem_req_valid_o || mem_req_ready_i;
  // Gated by reset so no requester sees an accept while the block is held in reset.
  assign req_ready_o = (stage_ready && !rst_i) ? grant_oh : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_tag_o   <= '0;
      rr_ptr          <= '0;
    end else if (stage_ready) begin
      mem_req_valid_o <= found;
      if (found) begin
        mem_req_addr_o <= sel_addr;
        mem_req_tag_o  <= {grant_idx, sel_tag};
        rr_ptr         <= next_ptr;
      end
    end
  end

  logic                rsp_drain;
  logic                rsp_capture;
  logic [NUM_REQS-1:0] rsp_dec;

  // Out-of-range indices decode to all zero, so such responses are swallowed.
  always_comb begin
    rsp_dec = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      rsp_dec[k] = (mem_rsp_tag_i[TAG_OUT_WIDTH-1:TAG_IN_WIDTH] == IDX_W'(k));
    end
  end

  assign rsp_drain       = |(rsp_valid_o & rsp_ready_i);
  assign mem_rsp_ready_o = !(|rsp_valid_o) || rsp_drain;
  assign rsp_capture     = mem_rsp_valid_i && mem_rsp_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_tag_o   <= '0;
    end else if (rsp_capture) begin
      rsp_valid_o <= rsp_dec;
      rsp_data_o  <= mem_rsp_data_i;
      rsp_tag_o   <= mem_rsp_tag_i[TAG_IN_WIDTH-1:0];
    end else if (rsp_drain) begin
      rsp_valid_o <= '0;
    end
  end

`ifdef L2_INSTR_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_cnt_o <= '0;
    end else if (mem_req_valid_o && !mem_req_ready_i && (perf_stall_cnt_o != '1)) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_to_l2_instr_arbiter.sv
// Directed bench for l1_to_l2_instr_arbiter: stimulus pushes expected L2 requests and
// requester responses into queues, independent monitors pop and compare on handshakes.
module tb_l1_to_l2_instr_arbiter;
  localparam int NR = 4;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int TOW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0][AW-1:0] addr_arr = '0;
  logic [NR-1:0][TW-1:0] tag_arr = '0;
  logic [NR-1:0] req_ready;
  logic mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic [TOW-1:0] mem_req_tag;
  logic mem_req_ready = 1'b1;
  logic mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic [TOW-1:0] mem_rsp_tag = '0;
  logic mem_rsp_ready;
  logic [NR-1:0] rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [NR-1:0] rsp_ready = '1;
`ifdef L2_INSTR_ARB_PERF_EN
  logic [31:0] perf_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [AW+TOW-1:0] exp_q[$];
  logic [2+TW+DW-1:0] exp_rsp_q[$];

  l1_to_l2_instr_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(addr_arr), .req_tag_i(tag_arr),
    .req_ready_o(req_ready),
    .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr),
    .mem_req_tag_o(mem_req_tag), .mem_req_ready_i(mem_req_ready),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .mem_rsp_tag_i(mem_rsp_tag), .mem_rsp_ready_o(mem_rsp_ready),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag),
    .rsp_ready_i(rsp_ready)
`ifdef L2_INSTR_ARB_PERF_EN
    , .perf_stall_cnt_o(perf_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // request monitor
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        check("mem_req_unexpected", {28'd0, mem_req_addr, mem_req_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [AW+TOW-1:0] e;
        e = exp_q.pop_front();
        check("mem_req", {28'd0, mem_req_addr, mem_req_tag}, {28'd0, e});
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NR; k++) begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          total++;
          if (exp_rsp_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected actual=idx%0d tag=%0h required=none", k, rsp_tag);
          end else begin
            logic [2+TW+DW-1:0] e;
            logic [1:0] kk;
            e = exp_rsp_q.pop_front();
            kk = 2'(k);
            if ({kk, rsp_tag, rsp_data} !== e) begin
              bad++;
              $display("FAIL rsp actual=idx%0d tag=%0h data=%0h required=idx%0d tag=%0h data=%0h",
                       k, rsp_tag, rsp_data[31:0], e[DW+TW+1:DW+TW], e[DW+TW-1:DW], e[31:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NR-1:0] grant_seq [5];
    logic [AW+TOW-1:0] exp_seq [5];
    grant_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_seq = '{{26'h100, 10'h010}, {26'h101, 10'h111}, {26'h102, 10'h212},
                {26'h103, 10'h313}, {26'h100, 10'h010}};

    // reset values, with every requester asking
    req_valid = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      addr_arr[k] = AW'(32'h100 + k);
      tag_arr[k] = TW'(8'h10 + k);
    end
    @(negedge clk);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
    check("rst_stage", {28'd0, mem_req_addr, mem_req_tag}, 64'd0);
    step();
    rst = 1'b0;

    // round robin with all valid
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_seq[i]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(grant_seq[i]));
      step();
    end
    req_valid = '0;
    repeat (2) step();

    // single requester 2, then rr_ptr=3 picks 3 ahead of 0 and 1
    addr_arr[2] = 26'h12345;
    tag_arr[2] = 8'h5A;
    exp_q.push_back({26'h12345, 10'h25A});
    exp_q.push_back({26'h103, 10'h313});
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_grant", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b1011;
    @(negedge clk);
    check("ptr_after_2", 64'(req_ready), 64'h8);
    step();
    req_valid = '0;
    repeat (2) step();

    // L2 stall with requester 1 held
    addr_arr[1] = 26'h0AAAA;
    tag_arr[1] = 8'h33;
    mem_req_ready = 1'b0;
    req_valid = 4'b0010;
    exp_q.push_back({26'h0AAAA, 10'h133});
    @(negedge clk);
    check("stall_first_grant", 64'(req_ready), 64'h2);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_hold", {28'd0, mem_req_addr, mem_req_tag}, {28'd0, 26'h0AAAA, 10'h133});
      step();
    end
    mem_req_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
`ifdef L2_INSTR_ARB_PERF_EN
    check("perf_stall_cnt", 64'(perf_cnt), 64'd5);
`endif
    repeat (2) step();

    // held response to requester 3
    rsp_ready = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = 10'h3C1;
    mem_rsp_data = {16{32'hA5A5A5A5}};
    exp_rsp_q.push_back({2'd3, 8'hC1, {16{32'hA5A5A5A5}}});
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsp_hold_valid", 64'(rsp_valid), 64'h8);
      check("rsp_hold_tag", 64'(rsp_tag), 64'hC1);
      check("rsp_hold_mem_ready", 64'(mem_rsp_ready), 64'd0);
      step();
    end
    rsp_ready = 4'b1000;
    @(negedge clk);
    check("rsp_release_mem_ready", 64'(mem_rsp_ready), 64'd1);
    step();
    @(negedge clk);
    check("rsp_after_drain", 64'(rsp_valid), 64'd0);
    step();

    // back-to-back responses with no bubble
    rsp_ready = '1;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = 10'h011;
    mem_rsp_data = {16{32'h11111111}};
    exp_rsp_q.push_back({2'd0, 8'h11, {16{32'h11111111}}});
    exp_rsp_q.push_back({2'd1, 8'h22, {16{32'h22222222}}});
    step();
    mem_rsp_tag = 10'h122;
    mem_rsp_data = {16{32'h22222222}};
    @(negedge clk);
    check("b2b_first", 64'(rsp_valid), 64'h1);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("b2b_second", 64'(rsp_valid), 64'h2);
    step();
    @(negedge clk);
    check("b2b_empty", 64'(rsp_valid), 64'd0);
    step();

    // reset while the request stage is stalled and a response is held
    mem_req_ready = 1'b0;
    rsp_ready = '0;
    req_valid = 4'b0010;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = 10'h277;
    exp_q.push_back({26'h0AAAA, 10'h133});
    step();
    req_valid = '0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_stalled", 64'(mem_req_valid), 64'd1);
    check("pre_rst_rsp", 64'(rsp_valid), 64'h4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    exp_q.delete();
    exp_rsp_q.delete();
    step();
    req_valid = 4'b0110;
    mem_req_ready = 1'b1;
    rsp_ready = '1;
    @(negedge clk);
    check("in_rst_req_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    exp_q.push_back({26'h0AAAA, 10'h133});
    @(negedge clk);
    check("post_rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("post_rst_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    repeat (3) step();

    check("req_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
